mi_nios_bl_ctrl: RTL and testbench
==================================

MI_NIOS_BL_CTRL -- requirements
Module: mi_nios_bl_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, meaning clocks per timeout tick (1 ms at 50 MHz).
REQ-002 SHALL have port clk  in  1  system clock.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port address  in  3  Avalon-MM register word select.
REQ-005 SHALL have port chipselect  in  1  slave select.
REQ-006 SHALL have port write_n  in  1  active-low write strobe.
REQ-007 SHALL have port writedata  in  32  write data.
REQ-008 SHALL have port readdata  out  32  read data, zero read latency (combinational from address).
REQ-009 SHALL have port bl_n  out  1  registered active-low backlight PWM drive.
REQ-010 SHALL have port irq  out  1  level interrupt, high while TO_FLAG and IRQ_EN are both 1.

Function
REQ-011 SHALL decode a write as chipselect=1 and write_n=0; unused address and unused bits SHALL be ignored on write and SHALL read 0.
REQ-012 SHALL map address 0 to CTRL: bit0 EN (rw), bit1 ACT (write-1 pulse, reads 0), bit2 IRQ_EN (rw).
REQ-013 SHALL map address 1 to LEVEL[7:0] (rw), the on brightness.
REQ-014 SHALL map address 2 to DIM[7:0] (rw), the dimmed brightness.
REQ-015 SHALL map address 3 to FADE[15:0] (rw), clocks per one-step change of current level; 0 = immediate.
REQ-016 SHALL map address 4 to TIMEOUT[15:0] (rw), idle ticks before dimming; 0 = never dim.
REQ-017 SHALL map address 5 to STATUS (ro except bit16): [7:0] CUR, [9:8] STATE, [16] TO_FLAG; writing 1 to bit16 SHALL clear TO_FLAG.
REQ-018 SHALL run a tick prescaler counting 0..TICK_DIV-1 and pulsing one clock on wrap.
REQ-019 SHALL hold an idle counter that increments on each tick, saturates at 0xFFFF, and clears on an ACT write, on any CTRL write setting EN from 0 to 1, and while EN=0.
REQ-020 SHALL derive GOAL: OFF if EN=0; DIM if EN=1, TIMEOUT!=0 and idle>=TIMEOUT; else ON. TARGET = 0, DIM, or LEVEL respectively.
REQ-021 SHALL set TO_FLAG in the cycle GOAL changes from ON to DIM; a simultaneous clear write SHALL lose to the set.
REQ-022 SHALL implement states OFF(0), RAMP(1), ON(2), DIMMED(3); STATE SHALL be RAMP whenever CUR!=TARGET, else equal to GOAL's state.
REQ-023 SHALL, with FADE!=0, step CUR by exactly 1 toward TARGET each time a fade counter reaches FADE-1, the fade counter restarting at 0; with FADE=0, SHALL load CUR=TARGET on the next clock.
REQ-024 SHALL retarget mid-ramp without reset of CUR: ramp direction follows the new TARGET on the next step.
REQ-025 SHALL hold the fade counter at 0 while CUR==TARGET.
REQ-026 SHALL run a free-running 8-bit PWM counter P incrementing every clock and register bl_n = NOT(P < CUR); CUR=0 gives bl_n constantly 1, CUR=255 gives 255/256 low duty.
REQ-027 SHALL compute register write effects and GOAL in the write cycle; CUR/STATE change no earlier than the following clock.

Reset
REQ-028 SHALL, on reset_n=0, asynchronously set CTRL=0, LEVEL=0xFF, DIM=0x20, FADE=0, TIMEOUT=0, TO_FLAG=0, CUR=0, STATE=OFF, all counters=0, bl_n=1, irq=0.
REQ-029 SHALL, on reset asserted mid-ramp, abandon the ramp and return to the reset values with no glitch low on bl_n.

Verification
REQ-030 Reset then read all addresses -> CTRL 0, LEVEL 0xFF, DIM 0x20, FADE 0, TIMEOUT 0, STATUS 0; bl_n=1 for 512 clocks.
REQ-031 FADE=0, LEVEL=0x80, EN=1 -> CUR=0x80 one clock later, STATE=ON, bl_n low exactly 128 of every 256 clocks.
REQ-032 FADE=4, LEVEL=0x10, EN=1 -> CUR increments every 4 clocks, reaches 0x10 after 64 clocks, STATE RAMP then ON; EN=0 -> ramps to 0, STATE OFF.
REQ-033 TICK_DIV=10, TIMEOUT=3, IRQ_EN=1, EN=1 -> after 30 clocks GOAL DIM, TO_FLAG=1, irq=1, CUR ramps to 0x20 (DIMMED); ACT write -> ramps back to LEVEL; STATUS write bit16=1 -> irq=0.
REQ-034 FADE=8, ramp 0->0xFF under way, at CUR=0x40 write LEVEL=0x20 -> CUR reverses and settles at 0x20, STATE ON.
REQ-035 Assert reset_n mid-ramp -> bl_n=1 and CUR=0 immediately, all registers at reset values.

Source files
------------

// File: rtl/mi_nios_bl_ctrl.sv
// Backlight controller: Avalon-MM registers, idle-timeout dimming,
// linear fade of the current level and 8-bit PWM drive.
module mi_nios_bl_ctrl #(
  parameter int TICK_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        bl_n,
  output logic        irq
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_RAMP = 2'd1,
    S_ON   = 2'd2,
    S_DIM  = 2'd3
  } state_t;

  logic        en, irq_en, to_flag;
  logic [7:0]  level, dim, cur, target, pwm;
  logic [15:0] fade, timeout, idle, fcnt;
  logic [TW-1:0] tcnt;
  state_t      goal, goal_q, state;

  logic wr, wr_ctrl, wr_stat, act, en_rise, tick;
  logic unused_wd;

  assign wr      = chipselect & ~write_n;
  assign wr_ctrl = wr && (address == 3'd0);
  assign wr_stat = wr && (address == 3'd5);
  assign act     = wr_ctrl & writedata[1];
  assign en_rise = wr_ctrl & writedata[0] & ~en;
  assign tick    = (tcnt == TW'(TICK_DIV - 1));
  assign unused_wd = ^writedata[31:17];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en      <= 1'b0;
      irq_en  <= 1'b0;
      level   <= 8'hFF;
      dim     <= 8'h20;
      fade    <= '0;
      timeout <= '0;
    end else if (wr) begin
      case (address)
        3'd0: begin
          en     <= writedata[0];
          irq_en <= writedata[2];
        end
        3'd1: level   <= writedata[7:0];
        3'd2: dim     <= writedata[7:0];
        3'd3: fade    <= writedata[15:0];
        3'd4: timeout <= writedata[15:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt <= '0;
      idle <= '0;
    end else begin
      tcnt <= tick ? '0 : tcnt + 1'b1;
      if (!en || act || en_rise)
        idle <= '0;
      else if (tick && idle != 16'hFFFF)
        idle <= idle + 16'd1;
    end
  end

  always_comb begin
    goal   = S_OFF;
    target = 8'h00;
    if (en) begin
      if (timeout != 16'd0 && idle >= timeout) begin
        goal   = S_DIM;
        target = dim;
      end else begin
        goal   = S_ON;
        target = level;
      end
    end
  end

  // Set outranks a same-cycle clear so an edge is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      goal_q  <= S_OFF;
      to_flag <= 1'b0;
    end else begin
      goal_q <= goal;
      if (goal == S_DIM && goal_q == S_ON)
        to_flag <= 1'b1;
      else if (wr_stat && writedata[16])
        to_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur  <= '0;
      fcnt <= '0;
    end else if (cur == target) begin
      fcnt <= '0;
    end else if (fade == 16'd0) begin
      cur  <= target;
      fcnt <= '0;
    end else if (fcnt >= fade - 16'd1) begin
      fcnt <= '0;
      cur  <= (cur < target) ? cur + 8'd1 : cur - 8'd1;
    end else begin
      fcnt <= fcnt + 16'd1;
    end
  end

  always_comb begin
    state = (cur != target) ? S_RAMP : goal;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm  <= '0;
      bl_n <= 1'b1;
    end else begin
      pwm  <= pwm + 8'd1;
      bl_n <= ~(pwm < cur);
    end
  end

  assign irq = to_flag & irq_en;

  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata = {29'd0, irq_en, 1'b0, en};
      3'd1: readdata = {24'd0, level};
      3'd2: readdata = {24'd0, dim};
      3'd3: readdata = {16'd0, fade};
      3'd4: readdata = {16'd0, timeout};
      3'd5: readdata = {15'd0, to_flag, 6'd0, state, cur};
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mi_nios_bl_ctrl.sv
// Directed bench for mi_nios_bl_ctrl.
// Small tick divider keeps timeout scenarios short.
module tb_mi_nios_bl_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd5;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        bl_n;
  logic        irq;

  int checks = 0;
  int errors = 0;

  mi_nios_bl_ctrl #(.TICK_DIV(10)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .bl_n       (bl_n),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; writedata = d;
    chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
    address = 3'd5;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_regs(input string tag);
    logic [31:0] exp [8];
    logic [31:0] d;
    exp = '{32'h0, 32'hFF, 32'h20, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      checks++;
      if (d !== exp[a]) begin
        errors++;
        $display("FAIL %s addr%0d got %h want %h", tag, a, d, exp[a]);
      end
    end
  endtask

  task automatic test_reset();
    int lows;
    do_reset();
    check_reset_regs("reset_regs");
    lows = 0;
    repeat (512) begin
      @(posedge clk); #1;
      if (bl_n !== 1'b1 || irq !== 1'b0) lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL reset_bl_n low_cycles %0d want 0", lows);
    end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    do_reset();
    wr(3'd1, 32'h00ABCD12);
    wr(3'd2, 32'hFFFFFF5A);
    wr(3'd3, 32'h12345678);
    wr(3'd4, 32'hFFFF0009);
    wr(3'd0, 32'hFFFFFFF8);
    wr(3'd6, 32'hFFFFFFFF);
    wr(3'd5, 32'hFFFFFFFF);
    rd(3'd1, d); checks++;
    if (d !== 32'h12) begin errors++; $display("FAIL reg_level got %h want 12", d); end
    rd(3'd2, d); checks++;
    if (d !== 32'h5A) begin errors++; $display("FAIL reg_dim got %h want 5a", d); end
    rd(3'd3, d); checks++;
    if (d !== 32'h5678) begin errors++; $display("FAIL reg_fade got %h want 5678", d); end
    rd(3'd4, d); checks++;
    if (d !== 32'h9) begin errors++; $display("FAIL reg_timeout got %h want 9", d); end
    rd(3'd0, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reg_ctrl_mask got %h want 0", d); end
    rd(3'd6, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reg_unused6 got %h want 0", d); end
    rd(3'd5, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reg_status_ro got %h want 0", d); end
    wr(3'd0, 32'h4);
    rd(3'd0, d); checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL reg_irq_en got %h want 4", d); end
    wr(3'd0, 32'h2);
    rd(3'd0, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reg_act_reads0 got %h want 0", d); end
  endtask

  task automatic test_immediate();
    logic [31:0] d;
    int lows;
    do_reset();
    wr(3'd1, 32'h80);
    wr(3'd0, 32'h1);
    rd(3'd5, d); checks++;
    if (d !== 32'h100) begin errors++; $display("FAIL imm_same_cycle got %h want 100", d); end
    @(posedge clk); #1;
    rd(3'd5, d); checks++;
    if (d !== 32'h280) begin errors++; $display("FAIL imm_loaded got %h want 280", d); end
    lows = 0;
    repeat (256) begin
      @(posedge clk); #1;
      if (bl_n === 1'b0) lows++;
    end
    checks++;
    if (lows != 128) begin errors++; $display("FAIL imm_duty lows %0d want 128", lows); end
  endtask

  task automatic test_fade();
    logic [31:0] d;
    int n, first;
    do_reset();
    wr(3'd3, 32'h4);
    wr(3'd1, 32'h10);
    wr(3'd0, 32'h1);
    n = 0; first = -1; d = '0;
    while (n < 200 && d[7:0] != 8'h10) begin
      @(posedge clk); #1;
      rd(3'd5, d);
      n++;
      if (first < 0 && d[7:0] == 8'h01) first = n;
      if (n == 30 && d[9:8] !== 2'd1) begin
        errors++; $display("FAIL fade_mid_state got %0d want 1", d[9:8]);
      end
    end
    checks += 4;
    if (first != 4) begin errors++; $display("FAIL fade_first_step at %0d want 4", first); end
    if (n != 64) begin errors++; $display("FAIL fade_up_time got %0d want 64", n); end
    if (d !== 32'h210) begin errors++; $display("FAIL fade_up_final got %h want 210", d); end
    wr(3'd0, 32'h0);
    n = 0;
    rd(3'd5, d);
    while (n < 200 && d[7:0] != 8'h00) begin
      @(posedge clk); #1;
      rd(3'd5, d);
      n++;
    end
    if (n != 64) begin errors++; $display("FAIL fade_down_time got %0d want 64", n); end
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL fade_down_final got %h want 0", d); end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    do_reset();
    wr(3'd1, 32'h80);
    wr(3'd4, 32'h3);
    wr(3'd0, 32'h5);
    @(posedge clk); #1;
    rd(3'd5, d); checks++;
    if (d !== 32'h280) begin errors++; $display("FAIL to_on got %h want 280", d); end
    for (int i = 0; i < 60 && irq !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL to_irq got %b want 1", irq); end
    @(posedge clk); #1;
    rd(3'd5, d); checks++;
    if (d !== 32'h10320) begin errors++; $display("FAIL to_dimmed got %h want 10320", d); end
    wr(3'd0, 32'h7);
    @(posedge clk); #1;
    rd(3'd5, d); checks++;
    if (d !== 32'h10280) begin errors++; $display("FAIL to_act got %h want 10280", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL to_irq_hold got %b want 1", irq); end
    wr(3'd5, 32'h10000);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL to_irq_clear got %b want 0", irq); end
    rd(3'd5, d); checks++;
    if (d !== 32'h280) begin errors++; $display("FAIL to_flag_clear got %h want 280", d); end
  endtask

  task automatic test_retarget();
    logic [31:0] d;
    logic [7:0] maxc;
    int n;
    do_reset();
    wr(3'd3, 32'h8);
    wr(3'd0, 32'h1);
    n = 0; d = '0;
    while (n < 800 && d[7:0] < 8'h40) begin
      @(posedge clk); #1;
      rd(3'd5, d);
      n++;
    end
    wr(3'd1, 32'h20);
    maxc = 8'h00; n = 0;
    rd(3'd5, d);
    while (n < 800 && d[7:0] != 8'h20) begin
      if (d[7:0] > maxc) maxc = d[7:0];
      @(posedge clk); #1;
      rd(3'd5, d);
      n++;
    end
    checks += 2;
    if (maxc > 8'h41 || maxc < 8'h40) begin
      errors++; $display("FAIL rt_reverse max %h want 40..41", maxc);
    end
    if (d !== 32'h220) begin errors++; $display("FAIL rt_settle got %h want 220", d); end
    repeat (30) @(posedge clk);
    #1;
    rd(3'd5, d); checks++;
    if (d !== 32'h220) begin errors++; $display("FAIL rt_hold got %h want 220", d); end
  endtask

  task automatic test_reset_midramp();
    logic [31:0] d;
    int bad;
    do_reset();
    wr(3'd3, 32'h8);
    wr(3'd4, 32'h5);
    wr(3'd0, 32'h5);
    n_wait: begin
      int n;
      n = 0; d = '0;
      while (n < 400 && d[7:0] < 8'h10) begin
        @(posedge clk); #1;
        rd(3'd5, d);
        n++;
      end
    end
    #3 reset_n = 1'b0;
    #1;
    checks += 2;
    if (bl_n !== 1'b1) begin errors++; $display("FAIL mr_bl_n got %b want 1", bl_n); end
    if (irq !== 1'b0) begin errors++; $display("FAIL mr_irq got %b want 0", irq); end
    check_reset_regs("mr_regs");
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bl_n !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mr_bl_n_hold lows %0d want 0", bad); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_regs();
    test_immediate();
    test_fade();
    test_timeout();
    test_retarget();
    test_reset_midramp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
